// File: rtl/calc_key_pkg.sv
// Shared definitions for the calc key-event scheduler.
// Key codes: digits 0..9 are their own value, then PLUS, MINUS, EQUAL.
// The one-hot helper maps a key code onto the 13-bit out_* pulse layout.
package calc_key_pkg;

  localparam int KW = 4;

  localparam logic [KW-1:0] KEY_PLUS  = 4'd10;
  localparam logic [KW-1:0] KEY_MINUS = 4'd11;
  localparam logic [KW-1:0] KEY_EQUAL = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Bit position equals key code: [9:0] digits, [10] plus, [11] minus, [12] equal.
  function automatic logic [12:0] key_onehot(input logic [KW-1:0] code);
    key_onehot = 13'd1 << code;
  endfunction

endpackage

// File: rtl/calc_key_fifo.sv
// Purpose: DEPTH x W circular FIFO holding pending key codes for the scheduler.
// Latency: push visible (count/head) the cycle after the write; head read is combinational.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_push, i_dat        write request and data
//   i_pop                remove head entry (ignored when empty)
//   i_flush              discard all entries (wins over push/pop)
//   o_dat                current head entry
//   o_full, o_empty      occupancy flags
//   o_count              number of stored entries
module calc_key_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [W-1:0]  i_dat,
  output logic [W-1:0]  o_dat,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_dat     = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A simultaneous pop frees the slot the push needs.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_dat;
  end

endmodule

// File: rtl/calc_key_sched.sv
// Purpose: queue keypad pulses and replay them to calc one at a time, GAP idle cycles apart.
// Latency: key at cycle n into an idle, empty block -> one-cycle out_* pulse at n+2; CE at n+1.
// Backpressure: none upstream; events beyond a full queue or losing the priority pick set dropped.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_key_push[9:0]         digit pulses (bit i = digit i)
//   i_key_plus/minus/equal  operator pulses
//   i_key_ce                clear pulse: flush queue, emit out_ce, clear dropped
//   i_halt                  calc in HALT: queued keys are discarded instead of issued
//   o_out_*                 registered, mutually exclusive one-cycle pulses to calc
//   o_busy                  queue non-empty or FSM not idle
//   o_fill                  queue occupancy
//   o_dropped               sticky lost-event flag
module calc_key_sched
  import calc_key_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP   = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [9:0]    i_key_push,
  input  logic          i_key_plus,
  input  logic          i_key_minus,
  input  logic          i_key_equal,
  input  logic          i_key_ce,
  input  logic          i_halt,
  output logic [9:0]    o_out_push,
  output logic          o_out_plus,
  output logic          o_out_minus,
  output logic          o_out_equal,
  output logic          o_out_ce,
  output logic          o_busy,
  output logic [CW-1:0] o_fill,
  output logic          o_dropped
);

  localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [GW-1:0] r_gap;
  logic [GW-1:0] w_gap_nxt;
  logic [13:0]   r_out;
  logic [13:0]   w_out_nxt;
  logic          r_dropped;
  logic          w_dropped_nxt;

  logic [12:0]   w_keys;
  logic          w_key_vld;
  logic          w_multi;
  logic [KW-1:0] w_key_code;
  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic [KW-1:0] w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;

  // Same bit layout as key codes, so the priority pick is just an index.
  assign w_keys    = {i_key_equal, i_key_minus, i_key_plus, i_key_push};
  assign w_key_vld = |w_keys;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign w_multi   = |(w_keys & (w_keys - 13'd1));

  // Priority EQUAL > PLUS > MINUS > highest digit; later assignments win.
  always_comb begin
    w_key_code = '0;
    for (int i = 0; i < 10; i++) begin
      if (i_key_push[i]) w_key_code = KW'(i);
    end
    if (i_key_minus) w_key_code = KEY_MINUS;
    if (i_key_plus)  w_key_code = KEY_PLUS;
    if (i_key_equal) w_key_code = KEY_EQUAL;
  end

  // CE discards the key captured alongside it.
  assign w_push = w_key_vld & ~i_key_ce & (~w_full | w_pop);

  calc_key_fifo #(
    .DEPTH (DEPTH),
    .W     (KW),
    .CW    (CW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_key_ce),
    .i_dat   (w_key_code),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_gap     <= '0;
      r_out     <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap     <= w_gap_nxt;
      r_out     <= w_out_nxt;
      r_dropped <= w_dropped_nxt;
    end
  end

  // r_gap is loaded with GAP as the pulse is registered and counts down through
  // the pulse cycle itself, so IDLE is re-entered exactly GAP cycles after the
  // pulse and the next pulse lands GAP+1 cycles after the previous one.
  always_comb begin
    w_state_nxt   = r_state;
    w_gap_nxt     = r_gap;
    w_pop         = 1'b0;
    w_issue       = 1'b0;
    w_out_nxt     = '0;
    w_dropped_nxt = r_dropped;

    if (i_key_ce) begin
      w_state_nxt   = ST_GAP;
      w_gap_nxt     = GW'(GAP);
      w_out_nxt     = 14'b1 << 13;
      w_dropped_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            w_pop = 1'b1;
            // In HALT the head is discarded silently and the FSM stays idle.
            if (!i_halt) begin
              w_issue     = 1'b1;
              w_state_nxt = ST_ISSUE;
              w_gap_nxt   = GW'(GAP);
            end
          end
        end
        ST_ISSUE, ST_GAP: begin
          w_gap_nxt   = (r_gap != '0) ? r_gap - GW'(1) : '0;
          w_state_nxt = (r_gap <= GW'(1)) ? ST_IDLE : ST_GAP;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_gap_nxt   = '0;
        end
      endcase

      if (w_issue) w_out_nxt = {1'b0, key_onehot(w_head)};
      if (w_multi || (w_key_vld && w_full && !w_pop)) w_dropped_nxt = 1'b1;
    end
  end

  assign o_out_push  = r_out[9:0];
  assign o_out_plus  = r_out[10];
  assign o_out_minus = r_out[11];
  assign o_out_equal = r_out[12];
  assign o_out_ce    = r_out[13];
  assign o_fill      = w_count;
  assign o_busy      = (w_count != '0) | (r_state != ST_IDLE);
  assign o_dropped   = r_dropped;

endmodule

// File: tb/tb_calc_key_sched.sv
// Bench for calc_key_sched: a timestamp/queue model predicts every output each
// cycle, and directed scenarios pin concrete cycle-exact expectations.
// Issued-key logs are packed as hex digits of (code+1): CE appears as E.
module tb_calc_key_sched;
  import calc_key_pkg::*;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [9:0]    key_push;
  logic          key_plus, key_minus, key_equal, key_ce, halt;
  logic [9:0]    out_push;
  logic          out_plus, out_minus, out_equal, out_ce;
  logic          busy;
  logic [CW-1:0] fill;
  logic          dropped;

  always #5 clk = ~clk;

  calc_key_sched #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_key_push  (key_push),
    .i_key_plus  (key_plus),
    .i_key_minus (key_minus),
    .i_key_equal (key_equal),
    .i_key_ce    (key_ce),
    .i_halt      (halt),
    .o_out_push  (out_push),
    .o_out_plus  (out_plus),
    .o_out_minus (out_minus),
    .o_out_equal (out_equal),
    .o_out_ce    (out_ce),
    .o_busy      (busy),
    .o_fill      (fill),
    .o_dropped   (dropped)
  );

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;
  int dut_log[$];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint log_val();
    longint v = 0;
    foreach (dut_log[i]) v = v * 16 + longint'(dut_log[i] + 1);
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  // A pulse in cycle p keeps the scheduler busy until p+GAP-1; a new head can
  // only be taken in a cycle c >= p+GAP. Codes: 0..12 keys, 13 CE, -1 none.
  int m_q[$];
  int m_last    = -100;
  int m_code    = -1;
  bit m_dropped = 1'b0;
  int cyc       = 0;

  always @(posedge clk) begin
    int c, n_keys, win;
    c   = cyc;
    cyc = cyc + 1;
    if (reset) begin
      m_q.delete();
      m_last    = -100;
      m_code    = -1;
      m_dropped = 1'b0;
    end else begin
      m_code = -1;
      n_keys = $countones(key_push) + int'(key_plus) + int'(key_minus) + int'(key_equal);
      win = -1;
      if (key_equal)      win = 12;
      else if (key_plus)  win = 10;
      else if (key_minus) win = 11;
      else begin
        for (int d = 9; d >= 0; d--) begin
          if (win < 0 && key_push[d]) win = d;
        end
      end
      if (key_ce) begin
        m_q.delete();
        m_code    = 13;
        m_last    = c + 1;
        m_dropped = 1'b0;
      end else begin
        if (m_q.size() > 0 && c >= m_last + GAP) begin
          int head;
          head = m_q.pop_front();
          if (!halt) begin
            m_code = head;
            m_last = c + 1;
          end
        end
        if (n_keys > 1) m_dropped = 1'b1;
        if (n_keys > 0) begin
          if (m_q.size() < DEPTH) m_q.push_back(win);
          else m_dropped = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      int ec;
      ec = m_code;
      check("cyc_push",  longint'(out_push), (ec >= 0 && ec < 10) ? (longint'(1) << ec) : 0);
      check("cyc_plus",  longint'(out_plus),  longint'(ec == 10));
      check("cyc_minus", longint'(out_minus), longint'(ec == 11));
      check("cyc_equal", longint'(out_equal), longint'(ec == 12));
      check("cyc_ce",    longint'(out_ce),    longint'(ec == 13));
      check("cyc_fill",  longint'(fill),      longint'(m_q.size()));
      check("cyc_busy",  longint'(busy),      longint'(m_q.size() != 0 || cyc < m_last + GAP));
      check("cyc_drop",  longint'(dropped),   longint'(m_dropped));

      if (out_ce)         dut_log.push_back(13);
      else if (out_equal) dut_log.push_back(12);
      else if (out_minus) dut_log.push_back(11);
      else if (out_plus)  dut_log.push_back(10);
      else begin
        for (int i = 0; i < 10; i++) begin
          if (out_push[i]) dut_log.push_back(i);
        end
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic clear_keys();
    key_push  = '0;
    key_plus  = 1'b0;
    key_minus = 1'b0;
    key_equal = 1'b0;
    key_ce    = 1'b0;
  endtask

  task automatic do_ce();
    key_ce = 1'b1;
    step(1);
    key_ce = 1'b0;
    step(4);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1;
    halt  = 1'b0;
    clear_keys();
    step(1);
    chk_on = 1'b1;
    check("rst_out",  longint'({out_ce, out_equal, out_minus, out_plus, out_push}), 0);
    check("rst_fill", longint'(fill), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_drop", longint'(dropped), 0);
    step(1);
    reset = 1'b0;
    step(2);

    // 1: single digit 5 -> pulse at n+2 only, busy low by n+5
    dut_log.delete();
    key_push = 10'd1 << 5;
    step(1);
    key_push = '0;
    check("t1_n1_push", longint'(out_push), 0);
    check("t1_n1_fill", longint'(fill), 1);
    step(1);
    check("t1_n2_push", longint'(out_push), longint'(10'b0000100000));
    step(1);
    check("t1_n3_push", longint'(out_push), 0);
    step(2);
    check("t1_busy", longint'(busy), 0);
    check("t1_log", log_val(), 'h6);
    step(2);

    // 2: digits 1, 2, then '+' on consecutive cycles -> n+2, n+5, n+8
    dut_log.delete();
    for (int k = 0; k < 12; k++) begin
      key_push = (k == 0) ? 10'd2 : (k == 1) ? 10'd4 : 10'd0;
      key_plus = (k == 2);
      if (k == 2) check("t2_d1", longint'(out_push), 'h2);
      if (k == 5) check("t2_d2", longint'(out_push), 'h4);
      if (k == 8) check("t2_plus", longint'(out_plus), 1);
      step(1);
    end
    key_plus = 1'b0;
    check("t2_log", log_val(), 'h23B);
    check("t2_drop", longint'(dropped), 0);

    // 3: '+' and digit 3 together -> only '+', dropped set
    dut_log.delete();
    key_plus = 1'b1;
    key_push = 10'd1 << 3;
    step(1);
    clear_keys();
    check("t3_drop", longint'(dropped), 1);
    step(1);
    check("t3_plus", longint'(out_plus), 1);
    step(4);
    check("t3_log", log_val(), 'hB);
    do_ce();
    check("t3_ce_clears", longint'(dropped), 0);

    // 4: seven digits back-to-back: queue full at n+6, 7th lost, six issued in order
    dut_log.delete();
    for (int k = 0; k < 25; k++) begin
      key_push = (k < 7) ? (10'd1 << k) : 10'd0;
      if (k == 6) begin
        check("t4_full", longint'(fill), 4);
        check("t4_drop_pre", longint'(dropped), 0);
      end
      if (k == 7) check("t4_drop_post", longint'(dropped), 1);
      step(1);
    end
    check("t4_log", log_val(), 'h123456);
    do_ce();

    // 5: digits 7, 8, 9 then CE -> only digit 7 and CE reach calc
    dut_log.delete();
    for (int k = 0; k < 15; k++) begin
      key_push = (k == 0) ? 10'd1 << 7 : (k == 1) ? 10'd1 << 8 : (k == 2) ? 10'd1 << 9 : 10'd0;
      key_ce   = (k == 3);
      if (k == 3) check("t5_fill_pre", longint'(fill), 2);
      if (k == 4) begin
        check("t5_ce", longint'(out_ce), 1);
        check("t5_fill", longint'(fill), 0);
        check("t5_drop", longint'(dropped), 0);
      end
      step(1);
    end
    check("t5_log", log_val(), 'h8E);

    // 6: halt drains 3 queued entries silently, CE still issued
    dut_log.delete();
    for (int k = 0; k < 13; k++) begin
      key_push = (k < 4) ? (10'd1 << (k + 1)) : 10'd0;
      halt     = (k >= 4);
      key_ce   = (k == 8);
      if (k >= 4 && k <= 7) check("t6_fill", longint'(fill), longint'(7 - k));
      if (k == 9) check("t6_ce", longint'(out_ce), 1);
      step(1);
    end
    halt   = 1'b0;
    key_ce = 1'b0;
    check("t6_log", log_val(), 'h2E);

    // 7: CE with keys in the same cycle -> keys discarded, dropped cleared and not re-set
    dut_log.delete();
    key_plus  = 1'b1;
    key_minus = 1'b1;
    step(1);
    clear_keys();
    check("t7_drop_set", longint'(dropped), 1);
    key_ce   = 1'b1;
    key_plus = 1'b1;
    key_push = 10'd1 << 2;
    step(1);
    clear_keys();
    check("t7_ce", longint'(out_ce), 1);
    check("t7_fill", longint'(fill), 0);
    check("t7_drop", longint'(dropped), 0);
    step(5);
    check("t7_log", log_val(), 'hE);

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
